// File: rtl/mkio_pkg.sv
// Shared types and field definitions for the MKIO bus-controller sequencer.
package mkio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_LOAD_CMD,
    S_SEND_CMD,
    S_TX_WAIT,
    S_FETCH,
    S_SEND_DATA,
    S_RESP_WAIT,
    S_LOG,
    S_DONE
  } state_t;

  localparam int CMD_ADDR_HI = 15;
  localparam int CMD_ADDR_LO = 11;
  localparam int CMD_TR      = 10;
  localparam int CMD_SUB_HI  = 9;
  localparam int CMD_SUB_LO  = 5;
  localparam int CMD_CNT_HI  = 4;
  localparam int CMD_CNT_LO  = 0;
  localparam int STAT_ME_BIT = 10;

  localparam logic [4:0] BROADCAST_ADDR = 5'd31;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_ADDR    = 2;
  localparam int ERR_MSG     = 3;

  // A count field of zero means a full 32-word message.
  function automatic logic [5:0] decode_count(input logic [4:0] cnt);
    return (cnt == 5'd0) ? 6'd32 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/mkio_cmd_table.sv
// Command-word table: one 16-bit entry per slot, synchronous write, asynchronous read.
module mkio_cmd_table #(
  parameter int NUM_SLOTS = 4,
  localparam int SW = $clog2(NUM_SLOTS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [SW-1:0] wr_slot,
  input  logic [15:0]   wr_data,
  input  logic [SW-1:0] rd_slot,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_slot] <= wr_data;
  end

  assign rd_data = mem[rd_slot];

endmodule

// File: rtl/mkio_bc_sched.sv
// MKIO bus-controller sequencer: walks the command table and runs BC->RT transfers.
// Optional single retry of failed slots is enabled by defining MKIO_BC_RETRY_EN.
module mkio_bc_sched
  import mkio_pkg::*;
#(
  parameter int         NUM_SLOTS    = 4,
  parameter logic [7:0] RESP_TIMEOUT = 8'd40,
  localparam int        SW           = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] slot_en,
  input  logic                 cfg_we,
  input  logic [SW-1:0]        cfg_slot,
  input  logic [15:0]          cfg_cmd,
  output logic [SW+4:0]        dmem_addr,
  input  logic [15:0]          dmem_data,
  output logic [15:0]          tx_data,
  output logic                 tx_cd,
  output logic                 tx_ready,
  input  logic                 tx_busy,
  input  logic                 rx_done,
  input  logic [15:0]          rx_data,
  input  logic                 p_error,
  output logic                 st_valid,
  output logic [SW-1:0]        st_slot,
  output logic [15:0]          st_word,
  output logic [3:0]           st_err,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [NUM_SLOTS-1:0] mask;
  logic [SW-1:0]        slot;
  logic [SW-1:0]        scan_slot;
  logic                 scan_found;
  logic [15:0]          cmd;
  logic [15:0]          tbl_cmd;
  logic [5:0]           remaining;
  logic [4:0]           idx;
  logic [7:0]           timer;
  logic                 seen_busy;
  logic                 res_hit;
  logic [3:0]           res_err;
  logic [15:0]          res_word;
`ifdef MKIO_BC_RETRY_EN
  logic                 retried;
`endif

  mkio_cmd_table #(.NUM_SLOTS(NUM_SLOTS)) u_table (
    .clk     (clk),
    .we      (cfg_we & ~busy),
    .wr_slot (cfg_slot),
    .wr_data (cfg_cmd),
    .rd_slot (slot),
    .rd_data (tbl_cmd)
  );

  assign dmem_addr = {slot, idx};
  assign st_slot   = slot;

  // Lowest enabled slot at or above the current one.
  always_comb begin
    scan_found = 1'b0;
    scan_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(slot))) begin
        scan_found = 1'b1;
        scan_slot  = SW'(i);
      end
    end
  end

  // A status word arriving on the timeout cycle wins over the timeout.
  always_comb begin
    res_hit  = rx_done || (timer == RESP_TIMEOUT);
    res_err  = 4'd0;
    res_word = 16'd0;
    if (rx_done) begin
      res_word          = rx_data;
      res_err[ERR_PARITY] = p_error;
      res_err[ERR_ADDR]   = (rx_data[CMD_ADDR_HI:CMD_ADDR_LO] != cmd[CMD_ADDR_HI:CMD_ADDR_LO]);
      res_err[ERR_MSG]    = rx_data[STAT_ME_BIT];
    end else begin
      res_err[ERR_TIMEOUT] = 1'b1;
    end
  end

  // Encoder handshake: tx_ready is a one-clock strobe issued only while tx_busy is low;
  // a word is complete once tx_busy has been seen high and then low again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      mask      <= '0;
      slot      <= '0;
      cmd       <= '0;
      remaining <= '0;
      idx       <= '0;
      timer     <= '0;
      seen_busy <= 1'b0;
      tx_data   <= '0;
      tx_cd     <= 1'b0;
      tx_ready  <= 1'b0;
      st_valid  <= 1'b0;
      st_word   <= '0;
      st_err    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MKIO_BC_RETRY_EN
      retried   <= 1'b0;
`endif
    end else begin
      tx_ready <= 1'b0;
      st_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mask  <= slot_en;
          slot  <= '0;
          busy  <= 1'b1;
          state <= S_SCAN;
        end
        S_SCAN: if (scan_found) begin
          slot  <= scan_slot;
          state <= S_LOAD_CMD;
        end else begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_LOAD_CMD: begin
          cmd       <= tbl_cmd;
          idx       <= '0;
          remaining <= decode_count(tbl_cmd[CMD_CNT_HI:CMD_CNT_LO]);
`ifdef MKIO_BC_RETRY_EN
          retried   <= 1'b0;
`endif
          if (tbl_cmd[CMD_TR]) begin
            st_valid <= 1'b1;
            st_word  <= 16'hFFFF;
            st_err   <= 4'd0;
            state    <= S_LOG;
          end else begin
            state <= S_SEND_CMD;
          end
        end
        S_SEND_CMD: if (!tx_busy) begin
          tx_ready  <= 1'b1;
          tx_cd     <= 1'b1;
          tx_data   <= cmd;
          seen_busy <= 1'b0;
          state     <= S_TX_WAIT;
        end
        S_TX_WAIT: if (tx_busy) begin
          seen_busy <= 1'b1;
        end else if (seen_busy) begin
          if (remaining != 6'd0) begin
            state <= S_FETCH;
          end else if (cmd[CMD_ADDR_HI:CMD_ADDR_LO] == BROADCAST_ADDR) begin
            st_valid <= 1'b1;
            st_word  <= 16'd0;
            st_err   <= 4'd0;
            state    <= S_LOG;
          end else begin
            timer <= '0;
            state <= S_RESP_WAIT;
          end
        end
        S_FETCH: state <= S_SEND_DATA;
        S_SEND_DATA: if (!tx_busy) begin
          tx_ready  <= 1'b1;
          tx_cd     <= 1'b0;
          tx_data   <= dmem_data;
          idx       <= idx + 5'd1;
          remaining <= remaining - 6'd1;
          seen_busy <= 1'b0;
          state     <= S_TX_WAIT;
        end
        S_RESP_WAIT: begin
          timer <= timer + 8'd1;
          if (res_hit) begin
`ifdef MKIO_BC_RETRY_EN
            if ((res_err != 4'd0) && !retried) begin
              retried   <= 1'b1;
              idx       <= '0;
              remaining <= decode_count(cmd[CMD_CNT_HI:CMD_CNT_LO]);
              state     <= S_SEND_CMD;
            end else begin
              st_valid <= 1'b1;
              st_word  <= res_word;
              st_err   <= res_err;
              state    <= S_LOG;
            end
`else
            st_valid <= 1'b1;
            st_word  <= res_word;
            st_err   <= res_err;
            state    <= S_LOG;
`endif
          end
        end
        S_LOG: if (slot == SW'(NUM_SLOTS - 1)) begin
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          slot  <= slot + 1'b1;
          state <= S_SCAN;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mkio_bc_sched.md
Name: mkio_bc_sched

Overview:
- Bus-controller sequencer for the MKIO channel.
- Walks a table of up to NUM_SLOTS command words and, for each enabled slot, transmits the command word, then its data words from an external data memory.
- Waits for the remote terminal's status word, then logs the result per slot.
- Drives the same Manchester TX/RX word interfaces the remote-terminal devices use; BC->RT transfers only.

Parameters:
NUM_SLOTS, 4, number of command-table entries (power of 2, 2..16)
RESP_TIMEOUT, 8'd40, clocks allowed from end of last TX word to status-word rx_done
SW: localparam, $clog2(NUM_SLOTS), slot index width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse: run one pass over enabled slots
slot_en  in  NUM_SLOTS  per-slot enable mask, sampled at start
cfg_we  in  1  write command table (ignored while busy)
cfg_slot  in  SW  table index
cfg_cmd  in  16  command word {addr[15:11], tr[10], subaddr[9:5], count[4:0]}
dmem_addr  out  SW+5  data memory read address {slot, word_idx}
dmem_data  in  16  read data, valid 1 clk after dmem_addr
tx_data  out  16  word to encoder
tx_cd  out  1  1 = command sync, 0 = data sync
tx_ready  out  1  one-cycle word-valid strobe
tx_busy  in  1  encoder busy
rx_done  in  1  one-cycle received-word strobe
rx_data  in  16  received word
p_error  in  1  parity error, qualified by rx_done
st_valid  out  1  one-cycle log strobe
st_slot  out  SW  slot being logged
st_word  out  16  captured status word (0 if none)
st_err  out  4  bit0 timeout, bit1 parity, bit2 address mismatch, bit3 message-error (status bit 10)
busy  out  1  pass in progress
done  out  1  one-cycle end-of-pass pulse

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; table contents retained; takes priority over everything, including mid-transfer (tx_ready dropped same edge).
- States:
  - IDLE: start -> SCAN, latch slot_en, slot=0, busy=1; start while busy ignored.
  - SCAN: next enabled slot >= current -> LOAD_CMD; none -> DONE.
  - LOAD_CMD: decode entry; tr==1 -> LOG with st_err=0 and st_word=16'hFFFF (unsupported, skipped); else n = (count==0) ? 32 : count.
  - SEND_CMD: when tx_busy==0, tx_ready=1 for one clk, tx_cd=1, tx_data=cmd.
  - TX_WAIT: wait for tx_busy to be seen 1 then 0. Then if words remain -> FETCH; else RESP_WAIT with timer=0, or LOG immediately if addr==5'd31 (broadcast, no error).
  - FETCH: dmem_addr={slot,idx}; 1 clk later -> SEND_DATA.
  - SEND_DATA: as SEND_CMD with tx_cd=0, tx_data=dmem_data; idx++; -> TX_WAIT.
  - RESP_WAIT: timer++ each clk.
    - rx_done: capture rx_data; bit1=p_error, bit2=(rx_data[15:11]!=addr), bit3=rx_data[10] -> LOG.
    - timer==RESP_TIMEOUT with no rx_done: bit0=1, st_word=0 -> LOG.
    - rx_done on the timeout cycle counts as received.
  - LOG: st_valid one clk; slot++ -> SCAN; after last slot -> DONE.
  - DONE: done=1 one clk, busy=0 next clk -> IDLE.
- rx_done outside RESP_WAIT is ignored.
- idx is 5-bit; a 32-word message ends after idx 31 wraps to 0 (use a separate remaining counter, 6 bits).
- Mask 0: done within 3 clks of start.

Optional Feature:
MKIO_BC_RETRY_EN
- Defined: any nonzero st_err on a non-broadcast slot re-executes the slot once from SEND_CMD; only the second attempt is logged, with st_err bit3 unchanged.
- Undefined: no retry, log at first result.

Decomposition:
- Package mkio_pkg holds:
  - state enum
  - command-word field positions and BROADCAST_ADDR=5'd31
  - ST_ERR bit indices
  - word-count decode function (0 -> 32)
- One sub-module, mkio_cmd_table: NUM_SLOTS x 16 register file, sync write, async read.

Test Plan:
- Slot0 cmd 16'h0823 (addr1, count3), RT model replies 16'h0800 after 10 clk -> 4 tx_ready strobes (cd=1,0,0,0) with dmem words 0..2, st_valid slot0 st_word 16'h0800 st_err 0, done.
- Count field 0 -> exactly 32 data words, dmem_addr idx 0..31, then status log.
- No reply -> st_err=4'b0001 after RESP_TIMEOUT clks, st_word 0; with MKIO_BC_RETRY_EN, command sent twice, single log.
- Reply 16'h1400 (addr2, bit10) to addr1 command with p_error -> st_err=4'b1110.
- slot_en=4'b1010, slot3 addr 31 -> only slots 1,3 executed; slot3 logs err 0 without waiting for a reply.
- reset low during SEND_DATA -> next clk tx_ready=0, busy=0, IDLE; subsequent start runs cleanly.
